// File: rtl/axis_arbiter.sv
// Packet-granular round-robin arbiter: merges N_SRC AXI-Stream sources onto one
// registered master port and tags each beat with the index of its source.
module axis_arbiter #(
  parameter int unsigned WORD_W         = 8,
  parameter int unsigned BUS_W          = 8,
  parameter int unsigned N_SRC          = 4,
  localparam int unsigned WORDS_PER_BEAT = BUS_W / WORD_W,
  localparam int unsigned ID_W           = $clog2(N_SRC)
) (
  input  logic                                             clk,
  input  logic                                             rstn,
  input  logic [N_SRC-1:0]                                 s_valid,
  output logic [N_SRC-1:0]                                 s_ready,
  input  logic [N_SRC-1:0]                                 s_last,
  input  logic [N_SRC-1:0][WORDS_PER_BEAT-1:0]             s_keep,
  input  logic [N_SRC-1:0][WORDS_PER_BEAT-1:0][WORD_W-1:0] s_data,
  output logic                                             m_valid,
  input  logic                                             m_ready,
  output logic                                             m_last,
  output logic [WORDS_PER_BEAT-1:0]                        m_keep,
  output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]            m_data,
  output logic [ID_W-1:0]                                  m_id
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e                              state_q, state_d;
  logic [ID_W-1:0]                     owner_q, owner_d;
  logic [ID_W-1:0]                     ptr_q, ptr_d;
  logic                                m_valid_q, m_valid_d;
  logic                                m_last_q, m_last_d;
  logic [WORDS_PER_BEAT-1:0]           m_keep_q, m_keep_d;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] m_data_q, m_data_d;
  logic [ID_W-1:0]                     m_id_q, m_id_d;

  logic            load;
  logic            idle_found;
  logic [ID_W-1:0] idle_gnt;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] gnt_next;
  logic            xfer;

  // Round-robin scan starting at ptr; explicit wrap so N_SRC need not be a power of two.
  always_comb begin
    idle_found = 1'b0;
    idle_gnt   = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      int unsigned     idx;
      logic [ID_W-1:0] idx_id;
      idx = 32'(ptr_q) + i;
      if (idx >= N_SRC) idx = idx - N_SRC;
      idx_id = ID_W'(idx);
      if (!idle_found && s_valid[idx_id]) begin
        idle_found = 1'b1;
        idle_gnt   = idx_id;
      end
    end
  end

  // Grant selection, ready fan-out and arbiter next state.
  always_comb begin
    load     = !m_valid_q || m_ready;
    gnt_vld  = (state_q == StLocked) || idle_found;
    gnt      = (state_q == StLocked) ? owner_q : idle_gnt;
    gnt_next = (gnt == ID_W'(N_SRC - 1)) ? '0 : gnt + 1'b1;
    s_ready  = '0;
    // Ready is suppressed during reset even though the reset state would otherwise grant.
    if (rstn && gnt_vld) s_ready[gnt] = load;
    xfer     = s_valid[gnt] && s_ready[gnt];

    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      if (s_last[gnt]) begin
        // Packet done: next arbitration happens next cycle from the source after this one.
        state_d = StIdle;
        ptr_d   = gnt_next;
      end else begin
        state_d = StLocked;
        owner_d = gnt;
      end
    end
  end

  // Single-entry output register: capture on transfer, drain when the master accepts.
  always_comb begin
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_keep_d  = m_keep_q;
    m_data_d  = m_data_q;
    m_id_d    = m_id_q;
    if (xfer) begin
      m_valid_d = 1'b1;
      m_last_d  = s_last[gnt];
      m_keep_d  = s_keep[gnt];
      m_data_d  = s_data[gnt];
      m_id_d    = gnt;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      ptr_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_keep_q  <= '0;
      m_data_q  <= '0;
      m_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_keep_q  <= m_keep_d;
      m_data_q  <= m_data_d;
      m_id_q    <= m_id_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_keep  = m_keep_q;
  assign m_data  = m_data_q;
  assign m_id    = m_id_q;

endmodule

// File: tb/tb_axis_arbiter.sv
// Self-checking bench for axis_arbiter: source queues drive the slaves, a scoreboard
// holds every accepted beat and is compared against the master side in order.
module tb_axis_arbiter;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned BUS_W  = 32;
  localparam int unsigned N_SRC  = 4;
  localparam int unsigned WPB    = BUS_W / WORD_W;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [1:0]  id;
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } out_t;

  typedef struct {
    int          src;
    int          nbeats;
    logic [31:0] base;
    int          exp_slot;
  } pkt_vec_t;

  logic                                 clk;
  logic                                 rstn;
  logic [N_SRC-1:0]                     s_valid;
  logic [N_SRC-1:0]                     s_ready;
  logic [N_SRC-1:0]                     s_last;
  logic [N_SRC-1:0][WPB-1:0]            s_keep;
  logic [N_SRC-1:0][WPB-1:0][WORD_W-1:0] s_data;
  logic                                 m_valid;
  logic                                 m_ready;
  logic                                 m_last;
  logic [WPB-1:0]                       m_keep;
  logic [WPB-1:0][WORD_W-1:0]           m_data;
  logic [1:0]                           m_id;

  axis_arbiter #(
    .WORD_W (WORD_W),
    .BUS_W  (BUS_W),
    .N_SRC  (N_SRC)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_keep  (s_keep),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .m_keep  (m_keep),
    .m_data  (m_data),
    .m_id    (m_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t src_q[N_SRC][$];
  out_t  sb_q[$];
  out_t  out_log[$];
  int    xfer_src[$];
  int    xfer_cyc[$];
  bit    rdy_q[$];
  int    cyc;
  int    n_tests;
  int    n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit srcs_busy();
    for (int i = 0; i < N_SRC; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_pkt(input int src, input int nbeats, input logic [31:0] base);
    for (int k = 0; k < nbeats; k++) begin
      beat_t b;
      b.data = base + 32'(k);
      b.keep = 4'hF;
      b.last = (k == nbeats - 1);
      src_q[src].push_back(b);
    end
  endtask

  task automatic clear_logs();
    out_log.delete();
    xfer_src.delete();
    xfer_cyc.delete();
  endtask

  // One clock: drive at negedge, sample before the edge, account after the edge.
  task automatic cycle();
    logic [N_SRC-1:0] sv;
    bit               fire;
    bit               stall;
    out_t             cur;
    out_t             now;
    m_ready = (rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_q[i].size() != 0) begin
        s_valid[i] = 1'b1;
        s_data[i]  = src_q[i][0].data;
        s_keep[i]  = src_q[i][0].keep;
        s_last[i]  = src_q[i][0].last;
      end else begin
        s_valid[i] = 1'b0;
        s_data[i]  = '0;
        s_keep[i]  = '0;
        s_last[i]  = 1'b0;
      end
    end
    #4;
    sv    = s_valid & s_ready;
    fire  = m_valid && m_ready;
    stall = m_valid && !m_ready;
    cur   = {m_id, m_last, m_keep, m_data};
    chk("s_ready_onehot0", 64'($onehot0(s_ready)), 64'd1);
    if (stall) chk("s_ready_backpressure", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    cyc++;
    now = {m_id, m_last, m_keep, m_data};
    if (fire) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", 64'(cur), 64'd0);
      end else begin
        chk("beat", 64'(cur), 64'(sb_q.pop_front()));
        out_log.push_back(cur);
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (sv[i]) begin
        beat_t b;
        out_t  o;
        b = src_q[i].pop_front();
        o = {2'(i), b.last, b.keep, b.data};
        sb_q.push_back(o);
        xfer_src.push_back(i);
        xfer_cyc.push_back(cyc);
        chk("latency_valid", 64'(m_valid), 64'd1);
        chk("latency_beat", 64'(now), 64'(o));
      end
    end
    if (stall) begin
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_beat", 64'(now), 64'(cur));
    end
    @(negedge clk);
  endtask

  task automatic run_until_done(input string name, input int max);
    int n;
    n = 0;
    while ((srcs_busy() || sb_q.size() != 0 || m_valid) && n < max) begin
      cycle();
      n++;
    end
    chk({name, "_timeout"}, 64'(n < max), 64'd1);
  endtask

  pkt_vec_t tbl[8];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rstn    = 1'b0;
    m_ready = 1'b1;
    s_valid = '1;
    s_last  = '0;
    s_keep  = '1;
    s_data  = '1;

    // Reset state, with every source requesting.
    #12;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_keep", 64'(m_keep), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_id", 64'(m_id), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // All sources valid with two 2-beat packets each: round-robin 0,1,2,3,0,1,2,3.
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 4; s++) begin
        tbl[r*4+s] = '{src: s, nbeats: 2, base: 32'h1000 * 32'(r*4+s+1), exp_slot: r*4+s};
      end
    end
    clear_logs();
    foreach (tbl[i]) push_pkt(tbl[i].src, tbl[i].nbeats, tbl[i].base);
    run_until_done("all_valid", 100);
    chk("all_valid_count", 64'(out_log.size()), 64'd16);
    if (out_log.size() == 16) begin
      foreach (tbl[i]) begin
        for (int k = 0; k < tbl[i].nbeats; k++) begin
          chk("all_valid_id", 64'(out_log[2*tbl[i].exp_slot+k].id), 64'(tbl[i].src));
          chk("all_valid_data", 64'(out_log[2*tbl[i].exp_slot+k].data), 64'(tbl[i].base + 32'(k)));
        end
      end
    end
    if (xfer_cyc.size() == 16) chk("all_valid_no_bubble", 64'(xfer_cyc[15] - xfer_cyc[0]), 64'd15);

    // Single source 1, 3-beat packet.
    clear_logs();
    src_q[1].push_back('{data: 32'h11, keep: 4'hF, last: 1'b0});
    src_q[1].push_back('{data: 32'h22, keep: 4'hF, last: 1'b0});
    src_q[1].push_back('{data: 32'h33, keep: 4'hF, last: 1'b1});
    run_until_done("single", 50);
    chk("single_count", 64'(out_log.size()), 64'd3);
    if (out_log.size() == 3) begin
      chk("single_d0", 64'(out_log[0]), 64'({2'd1, 1'b0, 4'hF, 32'h11}));
      chk("single_d1", 64'(out_log[1]), 64'({2'd1, 1'b0, 4'hF, 32'h22}));
      chk("single_d2", 64'(out_log[2]), 64'({2'd1, 1'b1, 4'hF, 32'h33}));
    end

    // Lock under competition: source 2 stalls mid-packet while source 0 waits.
    clear_logs();
    src_q[2].push_back('{data: 32'h201, keep: 4'hF, last: 1'b0});
    cycle();
    push_pkt(0, 2, 32'h301);
    for (int i = 0; i < 5; i++) cycle();
    chk("lock_src0_waits", 64'(src_q[0].size()), 64'd2);
    src_q[2].push_back('{data: 32'h202, keep: 4'hF, last: 1'b0});
    src_q[2].push_back('{data: 32'h203, keep: 4'hF, last: 1'b1});
    run_until_done("lock", 50);
    chk("lock_xfer_count", 64'(xfer_src.size()), 64'd5);
    if (xfer_src.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("lock_order", 64'(xfer_src[i]), (i < 3) ? 64'd2 : 64'd0);
      chk("lock_release_next_cycle", 64'(xfer_cyc[3] - xfer_cyc[2]), 64'd1);
    end

    // Backpressure: m_ready 1,0,0,1 while the 4-beat packet is in flight.
    clear_logs();
    push_pkt(1, 4, 32'hA0);
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run_until_done("bp", 50);
    chk("bp_count", 64'(out_log.size()), 64'd4);
    if (out_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("bp_data", 64'(out_log[i].data), 64'(32'hA0 + 32'(i)));
    end

    // Partial last beat: 6 words over 4-word beats, upper data left unmasked.
    clear_logs();
    src_q[1].push_back('{data: 32'h44332211, keep: 4'b1111, last: 1'b0});
    src_q[1].push_back('{data: 32'hDEAD6655, keep: 4'b0011, last: 1'b1});
    run_until_done("partial", 50);
    chk("partial_count", 64'(out_log.size()), 64'd2);
    if (out_log.size() == 2) begin
      chk("partial_b1", 64'(out_log[0]), 64'({2'd1, 1'b0, 4'b1111, 32'h44332211}));
      chk("partial_b2", 64'(out_log[1]), 64'({2'd1, 1'b1, 4'b0011, 32'hDEAD6655}));
    end

    // Async reset after beat 2 of 4 from source 3; then sources 1 and 3 compete.
    clear_logs();
    push_pkt(3, 4, 32'hB0);
    cycle();
    cycle();
    chk("rstmid_src3_started", 64'(xfer_src.size() == 2 && xfer_src[1] == 3), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rstmid_m_valid", 64'(m_valid), 64'd0);
    chk("rstmid_s_ready", 64'(s_ready), 64'd0);
    src_q[3].delete();
    sb_q.delete();
    @(posedge clk);
    #1;
    chk("rstmid_m_valid_hold", 64'(m_valid), 64'd0);
    chk("rstmid_s_ready_hold", 64'(s_ready), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    clear_logs();
    push_pkt(1, 1, 32'hC1);
    push_pkt(3, 2, 32'hD1);
    run_until_done("rstmid", 50);
    chk("rstmid_count", 64'(out_log.size()), 64'd3);
    if (out_log.size() == 3) begin
      chk("rstmid_first_id", 64'(out_log[0].id), 64'd1);
      chk("rstmid_first_data", 64'(out_log[0].data), 64'hC1);
      chk("rstmid_then_src3", 64'(out_log[1].id), 64'd3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
